// File: rtl/axi_llc_tag_march_bist.sv
`default_nettype none
// ============================================================================
// Module   : axi_llc_tag_march_bist
// Purpose  : March-test BIST engine for the LLC tag SRAM; all ways are
//            written with a broadcast pattern and checked in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module axi_llc_tag_march_bist #(
    parameter int IndexWidth   = 6,
    parameter int NumWays      = 8,
    parameter int PatternWidth = 20,
    parameter int ReadLatency  = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    output logic                            ready_o,
    input  logic [1:0]                      mode_i,
    input  logic                            checker_i,
    output logic                            req_o,
    output logic                            we_o,
    output logic [IndexWidth-1:0]           index_o,
    output logic [PatternWidth-1:0]         wdata_o,
    input  logic [NumWays*PatternWidth-1:0] rdata_i,
    output logic [NumWays-1:0]              bist_res_o,
    output logic                            busy_o,
    output logic                            eoc_o
);

    localparam logic [1:0]            c_mode_x  = 2'd1;
    localparam logic [1:0]            c_mode_cm = 2'd2;
    localparam int                    c_cnt_w   = 3;
    localparam logic [c_cnt_w-1:0]    c_cnt_one = 1;
    localparam logic [IndexWidth-1:0] c_idx_max = '1;
    localparam logic [IndexWidth-1:0] c_idx_one = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_mode;
    logic                    r_checker;
    logic [2:0]              r_elem;
    logic [IndexWidth-1:0]   r_idx;
    logic                    r_phase;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_req;
    logic                    r_we;
    logic                    r_eoc;
    logic [IndexWidth-1:0]   r_index;
    logic [PatternWidth-1:0] r_wdata;
    logic [PatternWidth-1:0] r_rexp;
    logic [NumWays-1:0]      r_res;
    logic [ReadLatency:1]    r_pv;
    logic [PatternWidth-1:0] r_pexp [1:ReadLatency];

    // Element descriptor: {last, has_rd, has_wr, pol, down}. For read/write
    // elements pol is the read polarity and the write uses its inverse.
    function automatic logic [4:0] elem_desc(input logic [1:0] mode, input logic [2:0] elem);
        logic [4:0] d;
        d = 5'b10100;
        case (mode)
            c_mode_x: begin
                case (elem)
                    3'd0:    d = 5'b00100;
                    3'd1:    d = 5'b01100;
                    3'd2:    d = 5'b01111;
                    default: d = 5'b11000;
                endcase
            end
            c_mode_cm: begin
                case (elem)
                    3'd0:    d = 5'b00100;
                    3'd1:    d = 5'b01100;
                    3'd2:    d = 5'b01110;
                    3'd3:    d = 5'b01101;
                    3'd4:    d = 5'b01111;
                    default: d = 5'b11000;
                endcase
            end
            default: d = 5'b10100;
        endcase
        return d;
    endfunction

    logic [PatternWidth-1:0] w_pat;

    generate
        for (genvar k = 0; k < PatternWidth; k++) begin : g_pat
            assign w_pat[k] = ((k % 2) == 0);
        end
    endgenerate

    logic                    w_accept;
    logic                    w_load;
    logic [1:0]              w_mode;
    logic                    w_checker;
    logic [4:0]              w_cur_desc;
    logic [4:0]              w_step_desc;
    logic [4:0]              w_nxt_desc;
    logic                    w_rw;
    logic                    w_idx_end;
    logic                    w_run_last;
    logic [2:0]              w_nxt_elem;
    logic [IndexWidth-1:0]   w_nxt_idx;
    logic                    w_nxt_phase;
    logic                    w_nxt_wr;
    logic                    w_nxt_pol;
    logic [PatternWidth-1:0] w_nxt_word;
    logic [NumWays-1:0]      w_mis;
    logic                    w_unused;

    assign w_accept    = (r_state == ST_IDLE) && start_i;
    assign w_mode      = w_accept ? mode_i : r_mode;
    assign w_checker   = w_accept ? checker_i : r_checker;
    assign w_cur_desc  = elem_desc(r_mode, r_elem);
    assign w_step_desc = elem_desc(r_mode, r_elem + 3'd1);
    assign w_rw        = w_cur_desc[3] & w_cur_desc[2];
    assign w_idx_end   = w_cur_desc[0] ? (r_idx == '0) : (r_idx == c_idx_max);
    assign w_run_last  = w_cur_desc[4] & w_idx_end & (r_phase | ~w_rw);
    assign w_load      = w_accept || ((r_state == ST_RUN) && !w_run_last);

    // Next-op sequencer: a read/write element stays on its index for the
    // write half, element boundaries jump straight to the next start index.
    always_comb begin
        w_nxt_elem  = r_elem;
        w_nxt_idx   = r_idx;
        w_nxt_phase = 1'b0;
        if (w_accept) begin
            w_nxt_elem = 3'd0;
            w_nxt_idx  = '0;
        end else if (w_rw && !r_phase) begin
            w_nxt_phase = 1'b1;
        end else if (w_idx_end) begin
            w_nxt_elem = r_elem + 3'd1;
            w_nxt_idx  = w_step_desc[0] ? c_idx_max : '0;
        end else if (w_cur_desc[0]) begin
            w_nxt_idx = r_idx - c_idx_one;
        end else begin
            w_nxt_idx = r_idx + c_idx_one;
        end
    end

    assign w_nxt_desc = elem_desc(w_mode, w_nxt_elem);
    assign w_nxt_wr   = w_nxt_desc[2] & (w_nxt_phase | ~w_nxt_desc[3]);
    assign w_nxt_pol  = w_nxt_desc[1] ^ (w_nxt_wr & w_nxt_desc[3]);
    assign w_nxt_word = (w_checker ? (w_pat ^ {PatternWidth{w_nxt_idx[0]}}) : '0)
                        ^ {PatternWidth{w_nxt_pol}};

    generate
        for (genvar w = 0; w < NumWays; w++) begin : g_way
            assign w_mis[w] = (rdata_i[w*PatternWidth +: PatternWidth] != r_pexp[ReadLatency]);
        end
    endgenerate

    assign w_unused = ^{w_cur_desc[1], w_step_desc[4:1], w_nxt_desc[4], w_nxt_desc[0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_mode    <= 2'd0;
            r_checker <= 1'b0;
            r_elem    <= 3'd0;
            r_idx     <= '0;
            r_phase   <= 1'b0;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_eoc     <= 1'b0;
            r_index   <= '0;
            r_wdata   <= '0;
            r_rexp    <= '0;
            r_res     <= '0;
            r_pv      <= '0;
            for (int k = 1; k <= ReadLatency; k++) begin
                r_pexp[k] <= '0;
            end
        end else begin
            r_eoc     <= 1'b0;
            r_pv[1]   <= r_req & ~r_we;
            r_pexp[1] <= r_rexp;
            for (int k = 2; k <= ReadLatency; k++) begin
                r_pv[k]   <= r_pv[k-1];
                r_pexp[k] <= r_pexp[k-1];
            end
            if (r_pv[ReadLatency]) begin
                r_res <= r_res | w_mis;
            end

            if (w_load) begin
                r_elem  <= w_nxt_elem;
                r_idx   <= w_nxt_idx;
                r_phase <= w_nxt_phase;
                r_req   <= 1'b1;
                r_we    <= w_nxt_wr;
                r_index <= w_nxt_idx;
                r_wdata <= w_nxt_wr ? w_nxt_word : '0;
                r_rexp  <= w_nxt_wr ? '0 : w_nxt_word;
            end else begin
                r_elem  <= 3'd0;
                r_idx   <= '0;
                r_phase <= 1'b0;
                r_req   <= 1'b0;
                r_we    <= 1'b0;
                r_index <= '0;
                r_wdata <= '0;
                r_rexp  <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state   <= ST_RUN;
                        r_mode    <= mode_i;
                        r_checker <= checker_i;
                        r_res     <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_run_last) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= c_cnt_w'(ReadLatency - 1);
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                        r_eoc   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o    = (r_state == ST_IDLE);
    assign busy_o     = (r_state != ST_IDLE);
    assign req_o      = r_req;
    assign we_o       = r_we;
    assign index_o    = r_index;
    assign wdata_o    = r_wdata;
    assign eoc_o      = r_eoc;
    assign bist_res_o = r_res;

endmodule
`default_nettype wire

// File: tb/tb_axi_llc_tag_march_bist.sv
`default_nettype none
// Testbench for axi_llc_tag_march_bist: directed and random march runs
// scored against an op-list reference model with a stuck-bit SRAM.
module tb_axi_llc_tag_march_bist;

    localparam int IW = 3;
    localparam int NW = 2;
    localparam int PW = 8;
    localparam int RL = 1;
    localparam int N  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             chk = 1'b0;
    logic             ready_o, req_o, we_o, busy_o, eoc_o;
    logic [IW-1:0]    index_o;
    logic [PW-1:0]    wdata_o;
    logic [NW*PW-1:0] rdata = '0;
    logic [NW-1:0]    bist_res_o;

    axi_llc_tag_march_bist #(
        .IndexWidth  (IW),
        .NumWays     (NW),
        .PatternWidth(PW),
        .ReadLatency (RL)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .ready_o   (ready_o),
        .mode_i    (mode),
        .checker_i (chk),
        .req_o     (req_o),
        .we_o      (we_o),
        .index_o   (index_o),
        .wdata_o   (wdata_o),
        .rdata_i   (rdata),
        .bist_res_o(bist_res_o),
        .busy_o    (busy_o),
        .eoc_o     (eoc_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: one-cycle read latency, optional stuck bit, junk when idle
    logic [PW-1:0] mem [NW][N];
    bit            f_en = 1'b0;
    int            f_way = 0, f_idx = 0, f_bit = 0;
    bit            f_val = 1'b0;
    logic [31:0]   junk;

    function automatic logic [PW-1:0] stuck(input logic [PW-1:0] d, input int w, input int i);
        logic [PW-1:0] r;
        r = d;
        if (f_en && w == f_way && i == f_idx) r[f_bit] = f_val;
        return r;
    endfunction

    always @(posedge clk) begin
        junk = $urandom;
        if (req_o && we_o)
            for (int w = 0; w < NW; w++) mem[w][index_o] <= stuck(wdata_o, w, int'(index_o));
        if (req_o && !we_o)
            for (int w = 0; w < NW; w++) rdata[w*PW +: PW] <= mem[w][index_o];
        else
            rdata <= junk[NW*PW-1:0];
    end

    typedef struct packed {
        logic [31:0]   cyc;
        logic          we;
        logic [IW-1:0] idx;
        logic [PW-1:0] data;
    } op_t;
    typedef struct packed {
        logic [31:0]   cyc;
        logic [NW-1:0] res;
    } eoc_t;

    op_t  exp_ops[$];
    eoc_t exp_eoc[$];
    op_t  mon_op;
    eoc_t mon_eoc;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // Reference: expand the march elements into a timed op list and track
    // what a faulty memory returns to derive the final per-way error flags.
    task automatic model_run(input int md, input bit ck, input int acc, output int k);
        int            el[$];
        int            t, i;
        int            ops[2];
        logic [PW-1:0] word;
        logic [NW-1:0] res;
        logic [PW-1:0] mm [NW][N];
        op_t           o;
        eoc_t          e;
        case (md)
            1:       el = '{10, 32, 141, 30};
            2:       el = '{10, 32, 41, 132, 141, 30};
            default: el = '{10};
        endcase
        t   = acc;
        res = '0;
        foreach (el[n]) begin
            for (int j = 0; j < N; j++) begin
                i      = (el[n] >= 100) ? N - 1 - j : j;
                ops[0] = (el[n] / 10) % 10;
                ops[1] = el[n] % 10;
                for (int s = 0; s < 2; s++) begin
                    if (ops[s] != 0) begin
                        t++;
                        word = (ck ? (8'h55 ^ {PW{i[0]}}) : 8'h00)
                               ^ {PW{(ops[s] == 2) || (ops[s] == 4)}};
                        o.cyc = 32'(t);
                        o.idx = IW'(i);
                        if (ops[s] <= 2) begin
                            o.we   = 1'b1;
                            o.data = word;
                            for (int w = 0; w < NW; w++) mm[w][i] = stuck(word, w, i);
                        end else begin
                            o.we   = 1'b0;
                            o.data = '0;
                            for (int w = 0; w < NW; w++) if (mm[w][i] != word) res[w] = 1'b1;
                        end
                        exp_ops.push_back(o);
                    end
                end
            end
        end
        k     = t - acc;
        e.cyc = 32'(t + RL + 1);
        e.res = res;
        exp_eoc.push_back(e);
    endtask

    // Monitor: pops expectations whenever the DUT presents an op or eoc
    always @(negedge clk) begin
        if (mon_en) begin
            check("bus_idle", 64'({we_o & ~req_o, (|wdata_o) & ~we_o, busy_o == ready_o}), 64'd0);
            if (req_o) begin
                if (exp_ops.size() == 0) begin
                    flag("op_extra", 64'({we_o, index_o, wdata_o}));
                end else begin
                    mon_op = exp_ops.pop_front();
                    check("op", 64'({32'(cyc), we_o, index_o, wdata_o}), 64'(mon_op));
                end
            end
            if (eoc_o) begin
                if (exp_eoc.size() == 0) begin
                    flag("eoc_extra", 64'(bist_res_o));
                end else begin
                    mon_eoc = exp_eoc.pop_front();
                    check("eoc", 64'({32'(cyc), bist_res_o}), 64'(mon_eoc));
                end
            end
        end
    end

    task automatic run(input int md, input bit ck, input bit hold);
        int acc, k;
        check("ready_before_start", 64'(ready_o), 64'd1);
        acc = cyc;
        model_run(md, ck, acc, k);
        start = 1'b1;
        mode  = 2'(md);
        chk   = ck;
        for (int n = 0; n < k + RL + 10; n++) begin
            @(negedge clk);
            if (cyc == acc + 1)
                check("accept", 64'({ready_o, busy_o, bist_res_o}), 64'({1'b0, 1'b1, 2'b00}));
            if (ready_o) break;
            if (!hold) begin
                start = 1'($urandom);
                mode  = 2'($urandom);
                chk   = 1'($urandom);
            end
        end
        if (!hold) start = 1'b0;
        check("ready_cycle", 64'(cyc), 64'(acc + k + RL + 2));
        check("ops_drained", 64'(exp_ops.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int acc, k;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({req_o, we_o, eoc_o, busy_o, ready_o, index_o, wdata_o, bist_res_o}),
              64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 2'b00}));
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        run(0, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        run(2, 1'b1, 1'b0);

        f_en = 1'b1; f_way = 1; f_idx = 5; f_bit = 3; f_val = 1'b0;
        run(1, 1'b0, 1'b0);
        f_en = 1'b0;
        @(negedge clk);
        check("res_sticky", 64'(bist_res_o), 64'(2'b10));
        run(1, 1'b0, 1'b0);

        run(1, 1'b1, 1'b1);
        run(1, 1'b1, 1'b0);
        run(3, 1'b1, 1'b0);

        repeat (10) begin
            f_en  = 1'($urandom_range(0, 1));
            f_way = $urandom_range(0, NW - 1);
            f_idx = $urandom_range(0, N - 1);
            f_bit = $urandom_range(0, PW - 1);
            f_val = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Abort a March C- run with reset after an error has been flagged
        f_en = 1'b1; f_way = 0; f_idx = 0; f_bit = 0; f_val = 1'b1;
        @(negedge clk);
        acc = cyc;
        model_run(2, 1'b0, acc, k);
        start = 1'b1; mode = 2'd2; chk = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 40 && cyc < acc + 20; n++) @(negedge clk);
        check("res_before_reset", 64'({32'(cyc), bist_res_o}), 64'({32'(acc + 20), 2'b01}));
        mon_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", 64'({req_o, ready_o, bist_res_o, busy_o, eoc_o}),
              64'({1'b0, 1'b1, 2'b00, 1'b0, 1'b0}));
        exp_ops.delete();
        exp_eoc.delete();
        mon_en = 1'b1;
        repeat (100) @(negedge clk);
        f_en = 1'b0;
        run(1, 1'b0, 1'b0);
        check("eoc_drained", 64'(exp_eoc.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
